dm_cache_wb: RTL

Parametrised direct-mapped, write-back, write-allocate cache between the CPU core and the line-wide RAM controller. It generalises the earlier fixed 16-line, 2-word cache in address width, word width, line size and depth. It adds a latched miss address, separate request/data buses with a valid/ready handshake, a flush mode that writes back all dirty lines, and saturating hit/miss counters.

---
 rtl/dm_cache_wb.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dm_cache_wb.sv
// Direct-mapped, write-back, write-allocate cache between the CPU core and a
// line-wide RAM controller, with flush of dirty lines and saturating hit/miss counters.
`timescale 1ns/1ps
module dm_cache_wb #(
   parameter int ADDR_W   = 10,
   parameter int WORD_W   = 10,
   parameter int OFFSET_W = 1,
   parameter int INDEX_W  = 4,
   parameter int CNT_W    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cpu_req,
   input  logic                          cpu_rw,
   input  logic [ADDR_W-1:0]             cpu_addr,
   input  logic [WORD_W-1:0]             cpu_wdata,
   output logic [WORD_W-1:0]             cpu_rdata,
   output logic                          cpu_ready,
   input  logic                          flush,
   output logic                          flush_done,
   output logic                          mem_req,
   output logic                          mem_rw,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [(WORD_W<<OFFSET_W)-1:0] mem_wdata,
   input  logic [(WORD_W<<OFFSET_W)-1:0] mem_rdata,
   input  logic                          mem_ready,
   output logic [CNT_W-1:0]              hit_count,
   output logic [CNT_W-1:0]              miss_count
);

   localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINE_W = WORD_W << OFFSET_W;
   localparam int WORDS  = 1 << OFFSET_W;
   localparam int LINES  = 1 << INDEX_W;

   typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, FLUSH} state_t;

   state_t state, next_state;

   logic [LINES-1:0]    valid, dirty;
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [LINE_W-1:0]   data_mem [LINES];

   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  line_idx;
   logic [OFFSET_W-1:0] req_off;
   logic                req_rw;
   logic [WORD_W-1:0]   req_wdata;
   logic                first_lookup;
   logic                flushing;

   logic [TAG_W-1:0]    cur_tag;
   logic [LINE_W-1:0]   cur_line, merged_line;
   logic [WORD_W-1:0]   sel_word;
   logic                hit, mem_fire, last_idx;

   logic                cpu_ready_n, flush_done_n, mem_req_n, mem_rw_n;
   logic [WORD_W-1:0]   cpu_rdata_n;
   logic [ADDR_W-1:0]   mem_addr_n;
   logic [LINE_W-1:0]   mem_wdata_n;

   assign cur_tag  = tag_mem[line_idx];
   assign cur_line = data_mem[line_idx];
   assign hit      = valid[line_idx] && (cur_tag == req_tag);
   assign mem_fire = mem_req && mem_ready;
   assign last_idx = (line_idx == {INDEX_W{1'b1}});

   always_comb begin
      sel_word    = '0;
      merged_line = cur_line;
      for (int k = 0; k < WORDS; k++) begin
         if (req_off == OFFSET_W'(k)) begin
            sel_word                         = cur_line[k*WORD_W +: WORD_W];
            merged_line[k*WORD_W +: WORD_W]  = req_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (flush)                       next_state = FLUSH;
            else if (cpu_req && !cpu_ready)  next_state = COMPARE;
         end
         COMPARE: begin
            if (hit)                                   next_state = IDLE;
            else if (valid[line_idx] && dirty[line_idx]) next_state = WRITEBACK;
            else                                       next_state = ALLOCATE;
         end
         WRITEBACK: if (mem_fire) next_state = flushing ? FLUSH : ALLOCATE;
         ALLOCATE:  if (mem_fire) next_state = COMPARE;
         FLUSH: begin
            if (valid[line_idx] && dirty[line_idx]) next_state = WRITEBACK;
            else if (last_idx)                      next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Next values of the registered outputs; memory fields only change when a
   // phase is (re)entered, so they stay stable for the whole handshake.
   always_comb begin
      cpu_ready_n  = 1'b0;
      flush_done_n = 1'b0;
      cpu_rdata_n  = cpu_rdata;
      mem_req_n    = 1'b0;
      mem_rw_n     = mem_rw;
      mem_addr_n   = mem_addr;
      mem_wdata_n  = mem_wdata;
      if (state == COMPARE && hit) begin
         cpu_ready_n = 1'b1;
         cpu_rdata_n = req_rw ? req_wdata : sel_word;
      end
      if (state == FLUSH && next_state == IDLE) flush_done_n = 1'b1;
      if (next_state == WRITEBACK) begin
         mem_req_n   = 1'b1;
         mem_rw_n    = 1'b1;
         mem_addr_n  = {cur_tag, line_idx, {OFFSET_W{1'b0}}};
         mem_wdata_n = cur_line;
      end else if (next_state == ALLOCATE) begin
         mem_req_n  = 1'b1;
         mem_rw_n   = 1'b0;
         mem_addr_n = {req_tag, line_idx, {OFFSET_W{1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_ready  <= 1'b0;
         cpu_rdata  <= '0;
         flush_done <= 1'b0;
         mem_req    <= 1'b0;
         mem_rw     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         cpu_ready  <= cpu_ready_n;
         cpu_rdata  <= cpu_rdata_n;
         flush_done <= flush_done_n;
         mem_req    <= mem_req_n;
         mem_rw     <= mem_rw_n;
         mem_addr   <= mem_addr_n;
         mem_wdata  <= mem_wdata_n;
      end
   end

   // The line index register doubles as the flush scan pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid        <= '0;
         dirty        <= '0;
         hit_count    <= '0;
         miss_count   <= '0;
         flushing     <= 1'b0;
         first_lookup <= 1'b0;
         line_idx     <= '0;
         req_tag      <= '0;
         req_off      <= '0;
         req_rw       <= 1'b0;
         req_wdata    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  line_idx <= '0;
                  flushing <= 1'b1;
               end else if (cpu_req && !cpu_ready) begin
                  req_tag      <= cpu_addr[ADDR_W-1 -: TAG_W];
                  line_idx     <= cpu_addr[OFFSET_W +: INDEX_W];
                  req_off      <= cpu_addr[OFFSET_W-1:0];
                  req_rw       <= cpu_rw;
                  req_wdata    <= cpu_wdata;
                  first_lookup <= 1'b1;
               end
            end
            COMPARE: begin
               if (hit) begin
                  if (req_rw) dirty[line_idx] <= 1'b1;
                  if (first_lookup && hit_count != {CNT_W{1'b1}})
                     hit_count <= hit_count + 1'b1;
               end else begin
                  first_lookup <= 1'b0;
                  if (miss_count != {CNT_W{1'b1}})
                     miss_count <= miss_count + 1'b1;
               end
            end
            WRITEBACK: if (mem_fire) dirty[line_idx] <= 1'b0;
            ALLOCATE: begin
               if (mem_fire) begin
                  valid[line_idx] <= 1'b1;
                  dirty[line_idx] <= 1'b0;
               end
            end
            FLUSH: begin
               if (!(valid[line_idx] && dirty[line_idx])) begin
                  if (last_idx) flushing <= 1'b0;
                  else          line_idx <= line_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == COMPARE && hit && req_rw)
            data_mem[line_idx] <= merged_line;
         if (state == ALLOCATE && mem_fire) begin
            data_mem[line_idx] <= mem_rdata;
            tag_mem[line_idx]  <= req_tag;
         end
      end
   end

endmodule
